// File: rtl/beta_step_ctrl.sv
// beta_step_ctrl: processor clock-enable controller for a single-step / free-run board.
//
// The processor advances one instruction per cpu_en pulse. Pulses are paced by
// rising edges of clk_div, which arrives as ordinary data in the clk domain.
// In free-run every clk_div rise yields a pulse. In single-step a debounced
// button press arms exactly one pulse on the next clk_div rise. A halt request
// from the processor parks the controller until the operator presses the
// button in single-step mode.
//
// Ports:
//   clk         in   system clock, all logic on its rising edge
//   rst         in   synchronous active-high reset
//   clk_div     in   divided square wave, sampled as data
//   mode_run    in   1 = free-run, 0 = single-step
//   step_btn    in   raw asynchronous push-button, active-high
//   halt_req    in   processor stop request (level)
//   cpu_en      out  registered one-cycle processor enable pulse
//   step_count  out  number of cpu_en pulses since reset (wraps)
//   state       out  FSM state: IDLE=0, RUN=1, STEP=2, HALTED=3
module beta_step_ctrl #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int CNT_W           = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clk_div,
    input  logic             mode_run,
    input  logic             step_btn,
    input  logic             halt_req,
    output logic             cpu_en,
    output logic [CNT_W-1:0] step_count,
    output logic [1:0]       state
);

    localparam int DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [DB_W-1:0] DB_MAX = DB_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_STEP   = 2'd2,
        ST_HALTED = 2'd3
    } state_t;

    logic            clk_div_q_r;
    logic            tick_s;
    logic            sync1_r;
    logic            sync2_r;
    logic [DB_W-1:0] db_cnt_r;
    logic            db_level_r;
    logic            press_r;
    state_t          state_r;
    state_t          state_nxt_s;
    logic            fire_s;
    logic            cpu_en_r;
    logic [CNT_W-1:0] step_count_r;

    // clk_div edge detector; resetting the history to 1 means a clk_div that
    // is already high when reset releases does not look like a fresh rise.
    always_ff @(posedge clk) begin
        if (rst) begin
            clk_div_q_r <= 1'b1;
        end else begin
            clk_div_q_r <= clk_div;
        end
    end

    assign tick_s = clk_div & ~clk_div_q_r;

    // Two-flop synchronizer for the asynchronous push-button.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_r <= 1'b0;
            sync2_r <= 1'b0;
        end else begin
            sync1_r <= step_btn;
            sync2_r <= sync1_r;
        end
    end

    // Debouncer: the synchronized level must disagree with the accepted level
    // for DEBOUNCE_CYCLES consecutive cycles before it is accepted. press_r
    // pulses for one cycle only when the accepted level turns 0 -> 1.
    always_ff @(posedge clk) begin
        if (rst) begin
            db_cnt_r   <= {DB_W{1'b0}};
            db_level_r <= 1'b0;
            press_r    <= 1'b0;
        end else if (sync2_r == db_level_r) begin
            db_cnt_r   <= {DB_W{1'b0}};
            db_level_r <= db_level_r;
            press_r    <= 1'b0;
        end else if (db_cnt_r == DB_MAX) begin
            db_cnt_r   <= {DB_W{1'b0}};
            db_level_r <= sync2_r;
            press_r    <= sync2_r;
        end else begin
            db_cnt_r   <= db_cnt_r + DB_W'(1);
            db_level_r <= db_level_r;
            press_r    <= 1'b0;
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // FSM next-state and pulse qualification. A halt request wins over a
    // coincident tick, so that tick issues no pulse.
    always_comb begin
        state_nxt_s = state_r;
        fire_s      = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (mode_run) begin
                    state_nxt_s = ST_RUN;
                end else if (press_r) begin
                    state_nxt_s = ST_STEP;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (halt_req) begin
                    state_nxt_s = ST_HALTED;
                end else begin
                    fire_s = tick_s;
                    if (!mode_run) begin
                        state_nxt_s = ST_IDLE;
                    end else begin
                        state_nxt_s = ST_RUN;
                    end
                end
            end
            ST_STEP: begin
                // Presses arriving here are ignored, never queued.
                if (halt_req) begin
                    state_nxt_s = ST_HALTED;
                end else if (tick_s) begin
                    fire_s      = 1'b1;
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_STEP;
                end
            end
            ST_HALTED: begin
                if (press_r && !mode_run) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_HALTED;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // Registered enable pulse and pulse counter; both update on the same edge
    // so step_count already includes the pulse while cpu_en is high.
    always_ff @(posedge clk) begin
        if (rst) begin
            cpu_en_r     <= 1'b0;
            step_count_r <= {CNT_W{1'b0}};
        end else if (fire_s) begin
            cpu_en_r     <= 1'b1;
            step_count_r <= step_count_r + CNT_W'(1);
        end else begin
            cpu_en_r     <= 1'b0;
            step_count_r <= step_count_r;
        end
    end

    assign cpu_en     = cpu_en_r;
    assign step_count = step_count_r;
    assign state      = state_r;

endmodule

// File: tb/tb_beta_step_ctrl.sv
// Testbench for beta_step_ctrl with a short debounce and a 4-bit counter.
// The driver pushes the expected step_count of every pulse it provokes into a
// queue; an independent monitor pops one entry per observed cpu_en pulse and
// also checks pulse width and placement relative to clk_div rises.
module tb_beta_step_ctrl;

    localparam int CNT_W = 4;
    localparam int DB    = 4;

    logic             clk;
    logic             rst;
    logic             clk_div;
    logic             mode_run;
    logic             step_btn;
    logic             halt_req;
    logic             cpu_en;
    logic [CNT_W-1:0] step_count;
    logic [1:0]       state;

    int total;
    int bad;
    logic [CNT_W-1:0] exp_q[$];
    logic [CNT_W-1:0] exp_cnt;

    logic mon_prev_en;
    logic mon_d1;
    logic mon_d2;

    beta_step_ctrl #(.DEBOUNCE_CYCLES(DB), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .clk_div    (clk_div),
        .mode_run   (mode_run),
        .step_btn   (step_btn),
        .halt_req   (halt_req),
        .cpu_en     (cpu_en),
        .step_count (step_count),
        .state      (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push_exp();
        exp_cnt = exp_cnt + CNT_W'(1);
        exp_q.push_back(exp_cnt);
    endtask

    // One clk_div period of 20 clk: 10 low, then a rise and 10 high.
    task automatic div_period(input bit fire);
        clk_div = 1'b0;
        cyc(10);
        clk_div = 1'b1;
        if (fire) push_exp();
        cyc(10);
    endtask

    task automatic press_btn();
        step_btn = 1'b1;
        cyc(10);
        step_btn = 1'b0;
        cyc(10);
    endtask

    // Monitor: samples on the falling edge, away from the active edge.
    initial begin
        logic [CNT_W-1:0] e;
        mon_prev_en = 1'b0;
        mon_d1      = 1'b0;
        mon_d2      = 1'b0;
        forever begin
            @(negedge clk);
            if (cpu_en === 1'b1) begin
                total++;
                if (mon_prev_en === 1'b1) begin
                    bad++;
                    $display("FAIL pulse_width: cpu_en high %0d cycles, expected 1", 2);
                end
                total++;
                if (!(mon_d1 === 1'b1 && mon_d2 === 1'b0)) begin
                    bad++;
                    $display("FAIL pulse_place: clk_div prev=%0b prev2=%0b, expected rise 1/0",
                             mon_d1, mon_d2);
                end
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL unexpected_pulse: step_count=%0d, expected no pulse", step_count);
                end else begin
                    e = exp_q.pop_front();
                    if (step_count !== e) begin
                        bad++;
                        $display("FAIL pulse_count: got %0d expected %0d", step_count, e);
                    end
                end
            end
            mon_d2      = mon_d1;
            mon_d1      = clk_div;
            mon_prev_en = cpu_en;
        end
    end

    // Directed stimulus.
    initial begin
        total    = 0;
        bad      = 0;
        exp_cnt  = '0;
        rst      = 1'b1;
        clk_div  = 1'b1;
        mode_run = 1'b0;
        step_btn = 1'b0;
        halt_req = 1'b0;
        cyc(3);
        chk("reset_state", state, 0);
        chk("reset_cpu_en", cpu_en, 0);
        chk("reset_count", step_count, 0);

        // Release with clk_div already high: no tick even in RUN.
        rst      = 1'b0;
        mode_run = 1'b1;
        cyc(5);
        chk("run_entry", state, 1);
        chk("no_tick_at_release", step_count, 0);

        // Free-run: 5 periods, 5 pulses.
        repeat (5) div_period(1'b1);
        chk("run_count", step_count, 5);
        chk("run_state", state, 1);
        mode_run = 1'b0;
        cyc(2);
        chk("run_to_idle", state, 0);

        // Single-step.
        step_btn = 1'b1;
        cyc(10);
        step_btn = 1'b0;
        chk("step_armed", state, 2);
        cyc(10);
        chk("step_release_quiet", state, 2);
        div_period(1'b1);
        chk("step_done", state, 0);
        chk("step_count", step_count, 6);

        // Bounce: toggling every 2 cycles must never be accepted.
        repeat (10) begin
            step_btn = ~step_btn;
            cyc(2);
        end
        step_btn = 1'b0;
        cyc(20);
        chk("bounce_state", state, 0);
        div_period(1'b0);
        chk("bounce_after_tick", state, 0);
        chk("bounce_count", step_count, 6);

        // Halt collides with a tick in RUN.
        mode_run = 1'b1;
        cyc(2);
        chk("halt_pre_run", state, 1);
        clk_div = 1'b0;
        cyc(10);
        clk_div  = 1'b1;
        halt_req = 1'b1;
        cyc(1);
        halt_req = 1'b0;
        chk("halted", state, 3);
        cyc(5);
        chk("halted_hold", state, 3);
        press_btn();
        chk("halted_run_press", state, 3);
        mode_run = 1'b0;
        press_btn();
        chk("halted_exit", state, 0);
        chk("halt_count", step_count, 6);

        // Wrap: 17 pulses from 6 pass through 15, 0, 1 and end at 7.
        mode_run = 1'b1;
        cyc(2);
        repeat (17) div_period(1'b1);
        chk("wrap_count", step_count, 7);
        mode_run = 1'b0;
        cyc(2);

        // Reset while a step is pending and clk_div is high.
        step_btn = 1'b1;
        cyc(10);
        step_btn = 1'b0;
        cyc(2);
        chk("pre_reset_step", state, 2);
        rst = 1'b1;
        cyc(1);
        chk("mid_reset_state", state, 0);
        chk("mid_reset_cpu_en", cpu_en, 0);
        chk("mid_reset_count", step_count, 0);
        rst     = 1'b0;
        exp_cnt = '0;
        cyc(10);
        chk("post_reset_idle", state, 0);
        div_period(1'b0);
        chk("step_discarded", step_count, 0);
        mode_run = 1'b1;
        cyc(2);
        div_period(1'b1);
        chk("post_reset_first", step_count, 1);
        mode_run = 1'b0;
        cyc(5);

        chk("scoreboard_empty", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/beta_step_ctrl.md
BETA_STEP_CTRL -- requirements
Module: beta_step_ctrl

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 1000000, number of clk cycles step_btn must be stable before it is accepted.
REQ-002 SHALL have parameter CNT_W, default 16, width of step_count.
REQ-003 SHALL have port clk  input  1  system clock; all logic on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port clk_div  input  1  divided square wave from the upstream divider, same clk domain; sampled as data, never used as a clock.
REQ-006 SHALL have port mode_run  input  1  1 = free-run, 0 = single-step; synchronous level.
REQ-007 SHALL have port step_btn  input  1  raw asynchronous push-button, active-high.
REQ-008 SHALL have port halt_req  input  1  synchronous level from the processor requesting a stop.
REQ-009 SHALL have port cpu_en  output  1  registered one-clk-cycle processor enable pulse.
REQ-010 SHALL have port step_count  output  CNT_W  number of cpu_en pulses issued since reset.
REQ-011 SHALL have port state  output  2  current FSM state: IDLE=0, RUN=1, STEP=2, HALTED=3.

Function
REQ-012 SHALL register clk_div into clk_div_q; tick = clk_div & ~clk_div_q, i.e. one cycle per clk_div rising edge.
REQ-013 SHALL pass step_btn through a 2-flop synchronizer before any other use.
REQ-014 SHALL debounce with a counter: cleared when the synchronized level equals the debounced level; otherwise incremented; on reaching DEBOUNCE_CYCLES-1, the debounced level takes the synchronized level and the counter clears.
REQ-015 SHALL generate press for one cycle when the debounced level goes 0->1; releases generate nothing.
REQ-016 SHALL implement FSM IDLE: cpu_en 0; mode_run=1 -> RUN; else press -> STEP; mode_run takes priority over a simultaneous press.
REQ-017 SHALL implement FSM RUN: every tick produces a cpu_en pulse; mode_run=0 -> IDLE.
REQ-018 SHALL implement FSM STEP: wait for the next tick, issue exactly one cpu_en pulse, then -> IDLE; presses received while in STEP are dropped, not queued.
REQ-019 SHALL implement FSM HALTED: cpu_en 0; leave to IDLE only on press while mode_run=0, with no pulse issued.
REQ-020 SHALL give halt_req=1 priority over all other transitions from RUN or STEP (-> HALTED); on a tick in the same cycle, no pulse is issued.
REQ-021 SHALL assert cpu_en in the clk cycle immediately after the cycle in which tick is true and the FSM qualifies it; width is exactly 1 cycle.
REQ-022 SHALL increment step_count in the same cycle cpu_en is asserted, wrapping from all-ones to 0.
REQ-023 SHALL in RUN leave the pulse spacing equal to the clk_div period, with no pulses lost or doubled.

Reset
REQ-024 SHALL, with rst=1 at a clk edge, set state=IDLE, cpu_en=0, step_count=0, the debounce counter to 0, the debounced level to 0, both synchronizer flops to 0, and clk_div_q=1.
REQ-025 SHALL take precedence over all other inputs, including a mid-operation reset during a pending STEP, which is discarded.
REQ-026 SHALL NOT produce a tick from a clk_div that is already high at reset release, because clk_div_q resets to 1.

Verification (bench DEBOUNCE_CYCLES=4, clk_div period 20 clk)
REQ-027 SHALL cover free-run: mode_run=1 for 5 clk_div periods -> exactly 5 cpu_en pulses, each 1 cycle wide, each one cycle after a clk_div rise; step_count=5.
REQ-028 SHALL cover single-step: mode_run=0, step_btn held 10 cycles -> state=STEP, then exactly 1 pulse on the next clk_div rise, then state=IDLE; step_count=1.
REQ-029 SHALL cover bounce: step_btn toggling every 2 cycles for 20 cycles, then low -> no press, state stays IDLE, cpu_en never asserts.
REQ-030 SHALL cover halt collision: in RUN, halt_req=1 in the tick cycle -> no pulse, state=HALTED; mode_run=1 with a press -> remains HALTED; mode_run=0 with a press -> IDLE, step_count unchanged.
REQ-031 SHALL cover wrap: CNT_W=4, 17 pulses in RUN -> step_count sequence reaches 15, then 0, then 1.
REQ-032 SHALL cover reset mid-STEP: rst held 1 cycle while clk_div is high -> all outputs at reset values, no pulse at the next edge, first pulse only after a fresh clk_div rise.
